// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/halt FSM, tick prescaler driving an external
// 3-digit BCD counter, and a free-running multiplexed 7-segment digit scanner.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 50000,
  parameter int SCAN_DIV = 1000,
  parameter int width    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_stop,
  input  logic             clear,
  input  logic [width-1:0] q0,
  input  logic [width-1:0] q1,
  input  logic [width-1:0] q2,
  input  logic [6:0]       bit0,
  input  logic [6:0]       bit1,
  input  logic [6:0]       bit2,
  output logic             cnt_enb,
  output logic             cnt_rst,
  output logic [2:0]       digit_sel,
  output logic [6:0]       seg_out,
  output logic             running,
  output logic             halted
);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [width-1:0]  NINE      = width'(9);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_RUN, S_PAUSE, S_HALT} state_e;

  state_e            state_q, state_d;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [2:0]        digit_sel_q, digit_sel_d;
  logic              cnt_enb_q, cnt_enb_d;
  logic              cnt_rst_q, cnt_rst_d;
  logic              running_q, running_d;
  logic              halted_q, halted_d;
  logic              at_max;

  assign at_max = (q0 == NINE) && (q1 == NINE) && (q2 == NINE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CLEAR;
      presc_q     <= '0;
      scan_q      <= '0;
      digit_sel_q <= 3'b001;
      cnt_enb_q   <= 1'b0;
      cnt_rst_q   <= 1'b1;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      scan_q      <= scan_d;
      digit_sel_q <= digit_sel_d;
      cnt_enb_q   <= cnt_enb_d;
      cnt_rst_q   <= cnt_rst_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_CLEAR;
    end else begin
      case (state_q)
        S_CLEAR: state_d = S_IDLE;
        S_IDLE:  if (start_stop) state_d = S_RUN;
        S_RUN: begin
          if (at_max)          state_d = S_HALT;
          else if (start_stop) state_d = S_PAUSE;
        end
        S_PAUSE: if (start_stop) state_d = S_RUN;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_CLEAR;
      endcase
    end
  end

  always_comb begin
    presc_d   = presc_q;
    cnt_enb_d = 1'b0;
    if (state_d == S_CLEAR || state_q == S_CLEAR || state_q == S_IDLE) begin
      presc_d = '0;
    end else if (state_q == S_RUN) begin
      if (presc_q == TICK_LAST) begin
        // Leaving RUN on the wrap edge keeps the completed period pending for resume.
        presc_d   = (state_d == S_RUN) ? '0 : presc_q;
        cnt_enb_d = (state_d == S_RUN);
      end else begin
        presc_d = presc_q + TICK_W'(1);
      end
    end

    cnt_rst_d = (state_d == S_CLEAR);
    running_d = (state_d == S_RUN);
    halted_d  = (state_d == S_HALT);

    if (scan_q == SCAN_LAST) begin
      scan_d      = '0;
      digit_sel_d = {digit_sel_q[1:0], digit_sel_q[2]};
    end else begin
      scan_d      = scan_q + SCAN_W'(1);
      digit_sel_d = digit_sel_q;
    end
  end

  always_comb begin
    case (digit_sel_q)
      3'b001:  seg_out = bit0;
      3'b010:  seg_out = bit1;
      3'b100:  seg_out = bit2;
      default: seg_out = 7'b0000000;
    endcase
  end

  assign cnt_enb   = cnt_enb_q;
  assign cnt_rst   = cnt_rst_q;
  assign running   = running_q;
  assign halted    = halted_q;
  assign digit_sel = digit_sel_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: models the external BCD counter and checks
// outputs one cycle after each step against expectations queued with the stimulus.
module tb_stopwatch_ctrl;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;

  localparam logic [13:0] M_ENB = 14'h2000;
  localparam logic [13:0] M_RST = 14'h1000;
  localparam logic [13:0] M_RUN = 14'h0800;
  localparam logic [13:0] M_HLT = 14'h0400;
  localparam logic [13:0] M_SEL = 14'h0380;
  localparam logic [13:0] M_SEG = 14'h007F;
  localparam logic [13:0] M_CTL = M_ENB | M_RST | M_RUN | M_HLT;
  localparam logic [13:0] M_ALL = M_CTL | M_SEL | M_SEG;

  typedef struct {
    string       tag;
    logic [13:0] mask;
    logic [13:0] val;
  } exp_t;

  logic       clk, rst, start_stop, clear;
  logic [4:0] q0, q1, q2;
  logic [6:0] bit0, bit1, bit2;
  logic       cnt_enb, cnt_rst, running, halted;
  logic [2:0] digit_sel;
  logic [6:0] seg_out;

  int   ctr;
  logic ctr_load;
  int   ctr_load_val;
  int   n_checks, n_errors;
  exp_t sb[$];

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .width(5)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear),
    .q0(q0), .q1(q1), .q2(q2), .bit0(bit0), .bit1(bit1), .bit2(bit2),
    .cnt_enb(cnt_enb), .cnt_rst(cnt_rst), .digit_sel(digit_sel),
    .seg_out(seg_out), .running(running), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External 000-999 BCD counter; wraps like real hardware so stray enables show up.
  always @(posedge clk) begin
    if (cnt_rst)       ctr <= 0;
    else if (ctr_load) ctr <= ctr_load_val;
    else if (cnt_enb)  ctr <= (ctr == 999) ? 0 : ctr + 1;
  end

  assign q0 = 5'(ctr % 10);
  assign q1 = 5'((ctr / 10) % 10);
  assign q2 = 5'(ctr / 100);

  function automatic logic [13:0] ctl(input logic enb, input logic crst,
                                      input logic run, input logic hlt);
    return {enb, crst, run, hlt, 10'b0};
  endfunction

  function automatic logic [13:0] dsp(input logic [2:0] sel, input logic [6:0] seg);
    return {4'b0, sel, seg};
  endfunction

  task automatic check(input string tag, input logic [13:0] observed,
                       input logic [13:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, then compare after the edge.
  task automatic step(input logic r, input logic ss, input logic clr, input string tag,
                      input logic [13:0] mask, input logic [13:0] val);
    exp_t        e;
    logic [13:0] obs;
    rst        = r;
    start_stop = ss;
    clear      = clr;
    if (mask != '0) sb.push_back('{tag, mask, val});
    @(posedge clk);
    #1;
    if (mask != '0) begin
      e   = sb.pop_front();
      obs = {cnt_enb, cnt_rst, running, halted, digit_sel, seg_out};
      check(e.tag, obs & e.mask, e.val);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    ctr          = 0;
    ctr_load     = 1'b0;
    ctr_load_val = 0;
    rst          = 1'b1;
    start_stop   = 1'b0;
    clear        = 1'b0;
    bit0         = 7'h7E;
    bit1         = 7'h4F;
    bit2         = 7'h6D;

    // Reset values, exit to IDLE, and the digit scan sequence
    step(1, 0, 0, "rst_hold", '0, '0);
    step(1, 0, 0, "rst_state", M_ALL, ctl(0, 1, 0, 0) | dsp(3'b001, 7'h7E));
    step(0, 0, 0, "rst_exit_idle", M_ALL, ctl(0, 0, 0, 0) | dsp(3'b001, 7'h7E));
    step(0, 0, 0, "scan_2", M_ALL, dsp(3'b010, 7'h4F));
    step(0, 0, 0, "scan_3", M_ALL, dsp(3'b010, 7'h4F));
    step(0, 0, 0, "scan_4", M_ALL, dsp(3'b100, 7'h6D));
    step(0, 0, 0, "scan_5", M_ALL, dsp(3'b100, 7'h6D));
    step(0, 0, 0, "scan_6", M_ALL, dsp(3'b001, 7'h7E));

    // Run: first tick TICK_DIV cycles after entry, then every TICK_DIV cycles
    step(0, 1, 0, "run_enter", M_CTL, ctl(0, 0, 1, 0));
    for (int i = 1; i <= 8; i++)
      step(0, 0, 0, $sformatf("run_tick_%0d", i), M_CTL, ctl(i % TICK_DIV == 0, 0, 1, 0));

    // Pause two cycles into a period, hold ten cycles, resume
    step(0, 0, 0, "run_mid", M_CTL, ctl(0, 0, 1, 0));
    step(0, 1, 0, "pause_enter", M_CTL, ctl(0, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      step(0, 0, 0, $sformatf("pause_hold_%0d", i), M_CTL, ctl(0, 0, 0, 0));
    step(0, 1, 0, "resume", M_CTL, ctl(0, 0, 1, 0));
    step(0, 0, 0, "resume_1", M_CTL, ctl(0, 0, 1, 0));
    step(0, 0, 0, "resume_2", M_CTL, ctl(1, 0, 1, 0));

    // clear wins over start_stop in the same cycle
    step(0, 1, 1, "clear_prio", M_CTL, ctl(0, 1, 0, 0));
    step(0, 0, 0, "clear_idle", M_CTL, ctl(0, 0, 0, 0));

    // Count from 998 up to 999 and halt
    ctr_load_val = 998;
    ctr_load     = 1'b1;
    step(0, 1, 0, "max_run", M_CTL, ctl(0, 0, 1, 0));
    ctr_load     = 1'b0;
    for (int i = 1; i <= 4; i++)
      step(0, 0, 0, $sformatf("max_tick_%0d", i), M_CTL, ctl(i == 4, 0, 1, 0));
    step(0, 0, 0, "max_reach_999", M_CTL, ctl(0, 0, 1, 0));
    step(0, 0, 0, "halt_enter", M_CTL, ctl(0, 0, 0, 1));
    for (int i = 0; i < 6; i++)
      step(0, (i % 2 == 0), 0, $sformatf("halt_hold_%0d", i), M_CTL, ctl(0, 0, 0, 1));
    check("ctr_final", 14'(ctr), 14'd999);

    // HALT leaves only via clear; start_stop ignored during CLEAR
    step(0, 0, 1, "halt_clear", M_CTL, ctl(0, 1, 0, 0));
    step(0, 1, 0, "clear_ignores_ss", M_CTL, ctl(0, 0, 0, 0));

    // Reset in mid-RUN discards the prescaler
    step(0, 1, 0, "rerun", M_CTL, ctl(0, 0, 1, 0));
    step(0, 0, 0, "rerun_1", M_CTL, ctl(0, 0, 1, 0));
    step(0, 0, 0, "rerun_2", M_CTL, ctl(0, 0, 1, 0));
    step(1, 0, 0, "rst_mid_run", M_ALL, ctl(0, 1, 0, 0) | dsp(3'b001, 7'h7E));
    step(0, 0, 0, "rst_mid_idle", M_CTL, ctl(0, 0, 0, 0));
    step(0, 1, 0, "post_rst_run", M_CTL, ctl(0, 0, 1, 0));
    for (int i = 1; i <= 4; i++)
      step(0, 0, 0, $sformatf("post_rst_tick_%0d", i), M_CTL, ctl(i == 4, 0, 1, 0));

    rst        = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
